alu_exec_unit: RTL

//  Multi-cycle ALU execution responder. Accepts {a,b,salu} requests from the issue stage

---
 rtl/alu_exec_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Multi-cycle 16-bit ALU responder. Requests and results use
//            valid/ready handshakes. Shifts run serially, one bit per cycle,
//            unless ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_salu,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_aout,
    output logic [3:0]       resp_fout,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    localparam logic [SHW-1:0] N_MAX = SHW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;
    logic [3:0]       flg_q, flg_d;

    logic             accept_w;
    logic             is_sub_w;
    logic [WIDTH-1:0] b_eff_w;
    logic [WIDTH:0]   sum_w;
    logic [SHW-1:0]   n_raw_w;
    logic [SHW-1:0]   ex_n_w;
    logic [WIDTH-1:0] ex_res_w;
    logic             ex_c_w;
    logic             ex_v_w;
    logic             ex_serial_w;
    logic [WIDTH-1:0] step_acc_w;
    logic             step_c_w;

    assign accept_w = req_valid && (state_q == ST_IDLE);

    always_comb begin
        is_sub_w = (req_salu == OP_SUB);
        b_eff_w  = is_sub_w ? ~req_b : req_b;
        sum_w    = {1'b0, req_a} + {1'b0, b_eff_w} + {{WIDTH{1'b0}}, is_sub_w};
        n_raw_w  = req_b[SHW-1:0];
        // Rotate wraps at 16, so only the low four bits matter; the others clip.
        if (req_salu == OP_SLR)
            ex_n_w = {{(SHW-4){1'b0}}, req_b[3:0]};
        else if (n_raw_w > N_MAX)
            ex_n_w = N_MAX;
        else
            ex_n_w = n_raw_w;
    end

`ifdef ALU_FAST_SHIFT_EN
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   sra_w;
    logic [WIDTH-1:0] rot_w;

    always_comb begin
        shl_w = {1'b0, req_a} << ex_n_w;
        shr_w = {req_a, 1'b0} >> ex_n_w;
        sra_w = $signed({req_a, 1'b0}) >>> ex_n_w;
        rot_w = (req_a << ex_n_w) | (req_a >> (N_MAX - ex_n_w));
    end
`endif

    always_comb begin
        ex_res_w    = '0;
        ex_c_w      = 1'b0;
        ex_v_w      = 1'b0;
        ex_serial_w = 1'b0;
        case (req_salu)
            OP_ADD, OP_SUB: begin
                ex_res_w = sum_w[WIDTH-1:0];
                ex_c_w   = sum_w[WIDTH];
                ex_v_w   = (req_a[WIDTH-1] == b_eff_w[WIDTH-1]) &&
                           (sum_w[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_AND: ex_res_w = req_a & req_b;
            OP_OR:  ex_res_w = req_a | req_b;
            OP_XOR: ex_res_w = req_a ^ req_b;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
`ifdef ALU_FAST_SHIFT_EN
                case (req_salu)
                    OP_SLL: begin
                        ex_res_w = shl_w[WIDTH-1:0];
                        ex_c_w   = shl_w[WIDTH];
                    end
                    OP_SRL: begin
                        ex_res_w = shr_w[WIDTH:1];
                        ex_c_w   = shr_w[0];
                    end
                    OP_SRA: begin
                        ex_res_w = sra_w[WIDTH:1];
                        ex_c_w   = sra_w[0];
                    end
                    default: begin
                        ex_res_w = rot_w;
                        ex_c_w   = (ex_n_w != '0) && rot_w[0];
                    end
                endcase
`else
                ex_res_w    = req_a;
                ex_serial_w = (ex_n_w != '0);
`endif
            end
            default: ex_res_w = '0;
        endcase
    end

    // kind_q holds req_salu[1:0]: 00 SLL, 01 SLR, 10 SRL, 11 SRA.
    always_comb begin
        step_acc_w = acc_q;
        step_c_w   = 1'b0;
        case (kind_q)
            2'b00: begin
                step_acc_w = {acc_q[WIDTH-2:0], 1'b0};
                step_c_w   = acc_q[WIDTH-1];
            end
            2'b01: begin
                step_acc_w = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                step_c_w   = acc_q[WIDTH-1];
            end
            2'b10: begin
                step_acc_w = {1'b0, acc_q[WIDTH-1:1]};
                step_c_w   = acc_q[0];
            end
            default: begin
                step_acc_w = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                step_c_w   = acc_q[0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_w) state_d = ex_serial_w ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_q == SHW'(1)) state_d = ST_DONE;
            ST_DONE:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_DONE);
        busy       = (state_q == ST_SHIFT);
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        flg_d  = flg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    acc_d  = ex_res_w;
                    cnt_d  = ex_n_w;
                    kind_d = req_salu[1:0];
                    flg_d  = {ex_res_w[WIDTH-1], (ex_res_w == '0), ex_c_w, ex_v_w};
                end
            end
            ST_SHIFT: begin
                acc_d = step_acc_w;
                cnt_d = cnt_q - SHW'(1);
                flg_d = {step_acc_w[WIDTH-1], (step_acc_w == '0), step_c_w, 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            kind_q <= '0;
            flg_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            flg_q  <= flg_d;
        end
    end

    assign resp_aout = acc_q;
    assign resp_fout = flg_q;

endmodule
`default_nettype wire
